// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO, multi-cycle Busy and Cancel flush.
// Optional accumulate ops (madd/maddu/msub/msubu) are built when MD_MADD_EN is defined.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HIWrite,
    input  logic        LOWrite,
    input  logic [31:0] WData,
    input  logic        Cancel,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] pend_q, pend_d;
    logic        pend_we_q, pend_we_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        op_valid, is_div, signed_op;
    logic [63:0] a_ext, b_ext, prod, result;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, quot, rem;

    // One 64x64 multiplier serves both signednesses via operand extension.
    always_comb begin
        is_div    = (MDOp[2:1] == 2'b01);
        signed_op = ~MDOp[0];
`ifdef MD_MADD_EN
        op_valid  = 1'b1;
`else
        op_valid  = ~MDOp[2];
`endif
        a_ext = signed_op ? {{32{A[31]}}, A} : {32'b0, A};
        b_ext = signed_op ? {{32{B[31]}}, B} : {32'b0, B};
        prod  = a_ext * b_ext;

        // Magnitude divide; 0x80000000 / -1 falls out as 0x80000000 rem 0.
        a_neg = signed_op & A[31];
        b_neg = signed_op & B[31];
        a_mag = a_neg ? -A : A;
        b_mag = b_neg ? -B : B;
        b_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag = a_mag / b_div;
        r_mag = a_mag % b_div;
        quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem   = a_neg ? -r_mag : r_mag;

        if (is_div)
            result = {rem, quot};
`ifdef MD_MADD_EN
        else if (MDOp[2])
            result = MDOp[1] ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
`endif
        else
            result = prod;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_we_d = pend_we_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (!Cancel) begin
                    if (Start && op_valid) begin
                        state_d   = RUN;
                        cnt_d     = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                        pend_d    = result;
                        pend_we_d = !(is_div && (B == 32'd0));
                    end else begin
                        if (HIWrite) hi_d = WData;
                        if (LOWrite) lo_d = WData;
                    end
                end
            end
            RUN: begin
                if (Cancel || cnt_q == 4'd1) begin
                    state_d   = IDLE;
                    cnt_d     = 4'd0;
                    pend_d    = 64'd0;
                    pend_we_d = 1'b0;
                    if (!Cancel && pend_we_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            pend_q    <= 64'd0;
            pend_we_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_we_q <= pend_we_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign Busy = (state_q == RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit against a plain-arithmetic HI/LO model.
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        CLK = 1'b0;
    logic        reset, Start, HIWrite, LOWrite, Cancel;
    logic [2:0]  MDOp;
    logic [31:0] A, B, WData;
    logic        Busy;
    logic [31:0] HI, LO;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_hi, exp_lo;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .CLK(CLK), .reset(reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
        .HIWrite(HIWrite), .LOWrite(LOWrite), .WData(WData), .Cancel(Cancel),
        .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 CLK = ~CLK;

`ifdef MD_MADD_EN
    localparam bit MADD = 1'b1;
`else
    localparam bit MADD = 1'b0;
`endif

    function automatic bit op_ok(input logic [2:0] op);
        return !op[2] || MADD;
    endfunction

    function automatic int exp_busy(input logic [2:0] op);
        if (!op_ok(op)) return 0;
        return (op == 3'b010 || op == 3'b011) ? DC : MC;
    endfunction

    // Updates exp_hi/exp_lo as the architecture says op should.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sp, sq, sr;
        longint unsigned up, acc;
        logic [31:0] uq, ur;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = longint'({32'b0, a}) * longint'({32'b0, b});
        acc = {exp_hi, exp_lo};
        case (op)
            3'b000: {exp_hi, exp_lo} = sp;
            3'b001: {exp_hi, exp_lo} = up;
            3'b010: if (b != 0) begin
                sq = longint'($signed(a)) / longint'($signed(b));
                sr = longint'($signed(a)) % longint'($signed(b));
                exp_lo = sq[31:0];
                exp_hi = sr[31:0];
            end
            3'b011: if (b != 0) begin
                uq = a / b;
                ur = a % b;
                exp_lo = uq;
                exp_hi = ur;
            end
            default: if (MADD) begin
                case (op[1:0])
                    2'b00: acc = acc + sp;
                    2'b01: acc = acc + up;
                    2'b10: acc = acc - sp;
                    default: acc = acc - up;
                endcase
                {exp_hi, exp_lo} = acc;
            end
        endcase
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int bcnt);
        @(negedge CLK);
        Start = 1'b1; MDOp = op; A = a; B = b;
        @(negedge CLK);
        Start = 1'b0; A = $urandom; B = $urandom;
        bcnt = 0;
        while (Busy === 1'b1 && bcnt < 40) begin
            bcnt++;
            @(negedge CLK);
        end
    endtask

    task automatic do_write(input logic hw, input logic lw, input logic [31:0] d);
        @(negedge CLK);
        HIWrite = hw; LOWrite = lw; WData = d;
        @(negedge CLK);
        HIWrite = 1'b0; LOWrite = 1'b0;
        if (hw) exp_hi = d;
        if (lw) exp_lo = d;
    endtask

    task automatic test_reset();
        reset = 1'b0; Start = 0; MDOp = 0; A = 0; B = 0;
        HIWrite = 0; LOWrite = 0; WData = 0; Cancel = 0;
        repeat (2) @(negedge CLK);
        checks += 3;
        if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", Busy); end
        if (HI !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h want=0", HI); end
        if (LO !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h want=0", LO); end
        reset = 1'b1;
        exp_hi = 0; exp_lo = 0;
    endtask

    task automatic test_mult();
        int n;
        run_op(3'b000, 32'hFFFFFFFE, 32'd3, n);
        checks += 3;
        if (n != MC) begin failures++; $display("FAIL mult_busy got=%0d want=%0d", n, MC); end
        if (HI !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h want=ffffffff", HI); end
        if (LO !== 32'hFFFFFFFA) begin failures++; $display("FAIL mult_lo got=%h want=fffffffa", LO); end
        exp_hi = 32'hFFFFFFFF; exp_lo = 32'hFFFFFFFA;
    endtask

    task automatic test_div();
        int n;
        run_op(3'b011, 32'd100, 32'd7, n);
        checks += 3;
        if (n != DC) begin failures++; $display("FAIL divu_busy got=%0d want=%0d", n, DC); end
        if (LO !== 32'd14) begin failures++; $display("FAIL divu_lo got=%h want=e", LO); end
        if (HI !== 32'd2) begin failures++; $display("FAIL divu_hi got=%h want=2", HI); end
        run_op(3'b010, -32'sd7, 32'd2, n);
        checks += 2;
        if (LO !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_lo got=%h want=fffffffd", LO); end
        if (HI !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_hi got=%h want=ffffffff", HI); end
        run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, n);
        checks += 2;
        if (LO !== 32'h80000000) begin failures++; $display("FAIL div_ovf_lo got=%h want=80000000", LO); end
        if (HI !== 32'd0) begin failures++; $display("FAIL div_ovf_hi got=%h want=0", HI); end
        exp_hi = 32'd0; exp_lo = 32'h80000000;
    endtask

    task automatic test_div_zero();
        int n;
        do_write(1'b1, 1'b1, 32'd0);
        do_write(1'b0, 1'b1, 32'h1234);
        checks += 1;
        if (LO !== 32'h1234) begin failures++; $display("FAIL mtlo got=%h want=1234", LO); end
        run_op(3'b010, 32'd55, 32'd0, n);
        checks += 3;
        if (n != DC) begin failures++; $display("FAIL divz_busy got=%0d want=%0d", n, DC); end
        if (LO !== 32'h1234) begin failures++; $display("FAIL divz_lo got=%h want=1234", LO); end
        if (HI !== 32'd0) begin failures++; $display("FAIL divz_hi got=%h want=0", HI); end
    endtask

    task automatic test_cancel();
        @(negedge CLK);
        Start = 1'b1; MDOp = 3'b001; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
        @(negedge CLK); Start = 1'b0;
        @(negedge CLK);
        @(negedge CLK); Cancel = 1'b1;
        @(negedge CLK); Cancel = 1'b0;
        checks += 3;
        if (Busy !== 1'b0) begin failures++; $display("FAIL cancel_busy got=%b want=0", Busy); end
        if (HI !== exp_hi) begin failures++; $display("FAIL cancel_hi got=%h want=%h", HI, exp_hi); end
        if (LO !== exp_lo) begin failures++; $display("FAIL cancel_lo got=%h want=%h", LO, exp_lo); end
        repeat (MC + 2) @(negedge CLK);
        checks += 2;
        if (Busy !== 1'b0) begin failures++; $display("FAIL cancel_late_busy got=%b want=0", Busy); end
        if ({HI, LO} !== {exp_hi, exp_lo})
            begin failures++; $display("FAIL cancel_late_hilo got=%h%h want=%h%h", HI, LO, exp_hi, exp_lo); end
    endtask

    task automatic test_start_during_busy();
        int n;
        @(negedge CLK);
        Start = 1'b1; MDOp = 3'b000; A = 32'd1000; B = 32'hFFFFFFF9;
        @(negedge CLK);
        Start = 1'b0; n = 1;
        @(negedge CLK);
        n++;
        Start = 1'b1; MDOp = 3'b011; A = 32'd9; B = 32'd4;
        @(negedge CLK);
        Start = 1'b0;
        while (Busy === 1'b1 && n < 40) begin n++; @(negedge CLK); end
        model(3'b000, 32'd1000, 32'hFFFFFFF9);
        checks += 2;
        if (n != MC) begin failures++; $display("FAIL restart_busy got=%0d want=%0d", n, MC); end
        if ({HI, LO} !== {exp_hi, exp_lo})
            begin failures++; $display("FAIL restart_hilo got=%h%h want=%h%h", HI, LO, exp_hi, exp_lo); end
    endtask

    task automatic test_write_rules();
        int n;
        // write during RUN is ignored
        @(negedge CLK);
        Start = 1'b1; MDOp = 3'b011; A = 32'd77; B = 32'd5;
        @(negedge CLK);
        Start = 1'b0; HIWrite = 1'b1; LOWrite = 1'b1; WData = 32'hDEADBEEF;
        @(negedge CLK);
        HIWrite = 1'b0; LOWrite = 1'b0; n = 2;
        while (Busy === 1'b1 && n < 40) begin n++; @(negedge CLK); end
        model(3'b011, 32'd77, 32'd5);
        checks += 1;
        if ({HI, LO} !== {exp_hi, exp_lo})
            begin failures++; $display("FAIL run_write got=%h%h want=%h%h", HI, LO, exp_hi, exp_lo); end
        // Start beats same-cycle writes
        @(negedge CLK);
        Start = 1'b1; MDOp = 3'b001; A = 32'd6; B = 32'd7;
        HIWrite = 1'b1; LOWrite = 1'b1; WData = 32'h55AA55AA;
        @(negedge CLK);
        Start = 1'b0; HIWrite = 1'b0; LOWrite = 1'b0;
        n = 0;
        while (Busy === 1'b1 && n < 40) begin n++; @(negedge CLK); end
        model(3'b001, 32'd6, 32'd7);
        checks += 1;
        if ({HI, LO} !== {exp_hi, exp_lo})
            begin failures++; $display("FAIL start_prio got=%h%h want=%h%h", HI, LO, exp_hi, exp_lo); end
        // Cancel in IDLE suppresses everything
        @(negedge CLK);
        Start = 1'b1; MDOp = 3'b000; Cancel = 1'b1;
        HIWrite = 1'b1; LOWrite = 1'b1; WData = 32'h13572468;
        @(negedge CLK);
        Start = 1'b0; Cancel = 1'b0; HIWrite = 1'b0; LOWrite = 1'b0;
        checks += 2;
        if (Busy !== 1'b0) begin failures++; $display("FAIL idle_cancel_busy got=%b want=0", Busy); end
        if ({HI, LO} !== {exp_hi, exp_lo})
            begin failures++; $display("FAIL idle_cancel_hilo got=%h%h want=%h%h", HI, LO, exp_hi, exp_lo); end
    endtask

    task automatic test_madd();
        int n;
        do_write(1'b1, 1'b1, 32'd0);
        do_write(1'b0, 1'b1, 32'hFFFFFFFF);
        run_op(3'b101, 32'd1, 32'd1, n);
        model(3'b101, 32'd1, 32'd1);
        checks += 3;
        if (n != (MADD ? MC : 0)) begin failures++; $display("FAIL maddu_busy got=%0d want=%0d", n, MADD ? MC : 0); end
        if (HI !== (MADD ? 32'd1 : 32'd0))
            begin failures++; $display("FAIL maddu_hi got=%h want=%h", HI, MADD ? 32'd1 : 32'd0); end
        if (LO !== (MADD ? 32'd0 : 32'hFFFFFFFF))
            begin failures++; $display("FAIL maddu_lo got=%h want=%h", LO, MADD ? 32'd0 : 32'hFFFFFFFF); end
        run_op(3'b110, 32'hFFFFFFF0, 32'd3, n);
        model(3'b110, 32'hFFFFFFF0, 32'd3);
        checks += 1;
        if ({HI, LO} !== {exp_hi, exp_lo})
            begin failures++; $display("FAIL msub_hilo got=%h%h want=%h%h", HI, LO, exp_hi, exp_lo); end
    endtask

    task automatic test_random();
        int n;
        logic [2:0] op;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: a = 32'h80000000;
                2: b = 32'hFFFFFFFF;
                3: b = b & 32'hF;
                default: ;
            endcase
            run_op(op, a, b, n);
            model(op, a, b);
            checks += 2;
            if (n != exp_busy(op))
                begin failures++; $display("FAIL rand_busy[%0d] op=%0d got=%0d want=%0d", i, op, n, exp_busy(op)); end
            if ({HI, LO} !== {exp_hi, exp_lo})
                begin failures++; $display("FAIL rand_hilo[%0d] op=%0d a=%h b=%h got=%h%h want=%h%h",
                                            i, op, a, b, HI, LO, exp_hi, exp_lo); end
        end
    endtask

    task automatic test_async_reset();
        do_write(1'b1, 1'b1, 32'hCAFEF00D);
        @(negedge CLK);
        Start = 1'b1; MDOp = 3'b010; A = 32'd1000; B = 32'd3;
        @(negedge CLK); Start = 1'b0;
        @(negedge CLK);
        #2 reset = 1'b0;
        #1;
        checks += 3;
        if (Busy !== 1'b0) begin failures++; $display("FAIL areset_busy got=%b want=0", Busy); end
        if (HI !== 32'd0) begin failures++; $display("FAIL areset_hi got=%h want=0", HI); end
        if (LO !== 32'd0) begin failures++; $display("FAIL areset_lo got=%h want=0", LO); end
        @(negedge CLK); reset = 1'b1;
        repeat (DC + 2) @(negedge CLK);
        checks += 1;
        if ({Busy, HI, LO} !== 65'd0)
            begin failures++; $display("FAIL areset_after got=%b %h %h want=0", Busy, HI, LO); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_cancel();
        test_start_during_busy();
        test_write_rules();
        test_madd();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
